// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Purpose: the data width and the stored-entry layout used by the receiver,
//          the receive FIFO and the future transmit FIFO.
// Contents:
//   UART_DATA_W      - width of a UART data byte
//   uart_rx_entry_t  - one stored frame: error flag plus data byte
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef struct packed {
    logic                   err;
    logic [UART_DATA_W-1:0] data;
  } uart_rx_entry_t;

endpackage : uart_pkg

// File: rtl/uart_fifo_mem.sv
// Register-array storage for the UART FIFOs.
// Purpose: DEPTH entries of uart_rx_entry_t with one synchronous write port
//          and one asynchronous (combinational) read port.
// Ports:
//   clk_i    - clock
//   rst_ni   - synchronous active-low reset, clears every entry to zero
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address
//   rdata_o  - read data, combinational from raddr_i
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   waddr_i,
  input  uart_rx_entry_t             wdata_i,
  input  logic [$clog2(DEPTH)-1:0]   raddr_i,
  output uart_rx_entry_t             rdata_o
);

  localparam int ADDR_W = $clog2(DEPTH);

  uart_rx_entry_t mem_q [DEPTH];

  // Entries are cleared on reset so the head outputs read zero before the
  // first write.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        mem_q[gi] <= '0;
      end else if (we_i && (waddr_i == ADDR_W'(gi))) begin
        mem_q[gi] <= wdata_i;
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// UART receive buffer.
// Purpose: captures each completed frame (data byte + error status) on the
//          rising edge of the receiver's done indication, stores it in a
//          circular FIFO and presents the oldest entry through a
//          first-word-fall-through valid/ready interface. Reports occupancy
//          and a sticky overflow flag.
// Optional feature: define UART_RX_FIFO_ALMOST_FULL_EN to add the registered
//          almost_full_o output (high when count_o >= AF_THRESH).
// Ports:
//   rx_clk_i       - clock shared with the receiver
//   rst_ni         - synchronous active-low reset
//   rx_data_i      - received byte
//   rx_done_i      - frame-complete level/pulse; its rising edge pushes
//   rx_error_i     - parity/stop error, may pulse any time during the frame
//   flush_i        - discard all entries and the pending error
//   rd_ready_i     - consumer accepts the head entry
//   rd_valid_o     - head entry available
//   rd_data_o      - head entry data
//   rd_error_o     - head entry error flag
//   count_o        - occupancy 0..DEPTH
//   full_o/empty_o - occupancy flags
//   overflow_o     - sticky: a frame was dropped because the FIFO was full
//   overflow_clr_i - clears overflow_o
//   almost_full_o  - (optional) count_o >= AF_THRESH
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 12
) (
  input  logic                       rx_clk_i,
  input  logic                       rst_ni,
  input  logic [UART_DATA_W-1:0]     rx_data_i,
  input  logic                       rx_done_i,
  input  logic                       rx_error_i,
  input  logic                       flush_i,
  input  logic                       rd_ready_i,
  output logic                       rd_valid_o,
  output logic [UART_DATA_W-1:0]     rd_data_o,
  output logic                       rd_error_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       overflow_o,
  input  logic                       overflow_clr_i
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  ,
  output logic                       almost_full_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_fifo: DEPTH must be a power of two and at least 2");
  end

  logic             done_q;
  logic             err_acc_q,   err_acc_d;
  logic             overflow_q,  overflow_d;
  logic [PTR_W-1:0] wr_ptr_q,    wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,    rd_ptr_d;
  logic [CNT_W-1:0] count_q,     count_d;

  logic           push;
  logic           pop;
  logic           full;
  logic           empty;
  logic           push_accept;
  logic           push_drop;
  uart_rx_entry_t wr_entry;
  uart_rx_entry_t head_entry;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // One push per done level, however long the receiver holds it.
  assign push = rx_done_i && !done_q;
  assign pop  = !empty && rd_ready_i;

  // When full, a simultaneous pop frees the slot the push needs. Flush
  // swallows the push without counting it as an overflow.
  assign push_accept = push && !flush_i && (!full || pop);
  assign push_drop   = push && !flush_i && full && !pop;

  // An error seen on the push cycle itself belongs to that frame.
  assign wr_entry.err  = err_acc_q | rx_error_i;
  assign wr_entry.data = rx_data_i;

  always_comb begin
    err_acc_d  = err_acc_q;
    overflow_d = overflow_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (flush_i) begin
      err_acc_d = 1'b0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
    end else begin
      // Every push closes the frame's error window, dropped or not.
      if (push) begin
        err_acc_d = 1'b0;
      end else if (rx_error_i) begin
        err_acc_d = 1'b1;
      end

      if (push_accept) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      if (push_accept && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push_accept) begin
        count_d = count_q - CNT_W'(1);
      end

      // Clear first so that a new overflow in the same cycle wins.
      if (overflow_clr_i) begin
        overflow_d = 1'b0;
      end
      if (push_drop) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge rx_clk_i) begin
    if (!rst_ni) begin
      done_q     <= 1'b0;
      err_acc_q  <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      done_q     <= rx_done_i;
      err_acc_q  <= err_acc_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (rx_clk_i),
    .rst_ni  (rst_ni),
    .we_i    (push_accept),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_entry)
  );

  assign rd_valid_o = !empty;
  assign rd_data_o  = head_entry.data;
  assign rd_error_o = head_entry.err;
  assign count_o    = count_q;
  assign full_o     = full;
  assign empty_o    = empty;
  assign overflow_o = overflow_q;

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af_thresh
    $error("uart_rx_fifo: AF_THRESH must be within 1..DEPTH");
  end

  logic almost_full_q;

  // Registered from next-state count so it tracks count_o cycle for cycle.
  always_ff @(posedge rx_clk_i) begin
    if (!rst_ni) begin
      almost_full_q <= 1'b0;
    end else begin
      almost_full_q <= (count_d >= CNT_W'(AF_THRESH));
    end
  end

  assign almost_full_o = almost_full_q;
`endif

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int AF_THRESH = 12;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_error;
  logic       flush;
  logic       rd_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_error;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       overflow_clr;
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  logic       almost_full;
`endif

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(DEPTH), .AF_THRESH(AF_THRESH)) dut (
    .rx_clk_i       (clk),
    .rst_ni         (rst_n),
    .rx_data_i      (rx_data),
    .rx_done_i      (rx_done),
    .rx_error_i     (rx_error),
    .flush_i        (flush),
    .rd_ready_i     (rd_ready),
    .rd_valid_o     (rd_valid),
    .rd_data_o      (rd_data),
    .rd_error_o     (rd_error),
    .count_o        (count),
    .full_o         (full),
    .empty_o        (empty),
    .overflow_o     (overflow),
    .overflow_clr_i (overflow_clr)
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    ,
    .almost_full_o  (almost_full)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of stored frames {err, data}.
  logic [8:0] mq[$];
  logic       m_err;
  logic       m_ovf;
  logic       m_prev_done;

  // Drive one clock cycle of inputs (called just after a falling edge) and
  // apply the buffer rules to the model; returns after the next falling edge.
  task automatic cycle(input logic done, input logic [7:0] data, input logic err,
                       input logic fl, input logic rdy, input logic oclr);
    logic push, pop, errbit;
    rx_done = done; rx_data = data; rx_error = err;
    flush = fl; rd_ready = rdy; overflow_clr = oclr;
    push = done && !m_prev_done;
    m_prev_done = done;
    pop = (mq.size() != 0) && rdy;
    if (fl) begin
      mq.delete();
      m_err = 1'b0;
    end else begin
      errbit = m_err | err;
      if (push) m_err = 1'b0;
      else if (err) m_err = 1'b1;
      if (pop) void'(mq.pop_front());
      if (oclr) m_ovf = 1'b0;
      if (push) begin
        if (mq.size() < DEPTH) mq.push_back({errbit, data});
        else m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  // One frame: done high for one cycle with the given error on that cycle.
  task automatic send(input logic [7:0] data, input logic err, input logic rdy);
    cycle(1'b1, data, err, 1'b0, rdy, 1'b0);
    cycle(1'b0, data, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx_done = 1'b0; rx_data = 8'h00; rx_error = 1'b0;
    flush = 1'b0; rd_ready = 1'b0; overflow_clr = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    m_err = 1'b0;
    m_ovf = 1'b0;
    m_prev_done = 1'b0;
  endtask

  // Pop everything, comparing each head against the model before its pop.
  task automatic drain(input string tag);
    int guard = 0;
    while (mq.size() != 0 && guard < 64) begin
      checks++;
      if (rd_valid !== 1'b1 || {rd_error, rd_data} !== mq[0]) begin
        errors++;
        $display("FAIL %s_head: got valid=%b err=%b data=%02h, want valid=1 entry=%03h",
                 tag, rd_valid, rd_error, rd_data, mq[0]);
      end
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      guard++;
    end
    checks++;
    if (rd_valid !== 1'b0 || empty !== 1'b1 || count !== 5'd0) begin
      errors++;
      $display("FAIL %s_empty: got valid=%b empty=%b count=%0d, want 0/1/0",
               tag, rd_valid, empty, count);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 8'h00 || rd_error !== 1'b0 || count !== 5'd0 ||
        full !== 1'b0 || empty !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b data=%02h err=%b count=%0d full=%b empty=%b ovf=%b, want 0/00/0/0/0/1/0",
               rd_valid, rd_data, rd_error, count, full, empty, overflow);
    end
    $display("test_reset done");
  endtask

  task automatic test_single_push();
    cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'hA5 || rd_error !== 1'b0 ||
        count !== 5'd1 || empty !== 1'b0) begin
      errors++;
      $display("FAIL single_push: got valid=%b data=%02h err=%b count=%0d empty=%b, want 1/a5/0/1/0",
               rd_valid, rd_data, rd_error, count, empty);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    drain("single");
    $display("test_single_push done");
  endtask

  task automatic test_error_accum();
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(20, 1'b0);
    send(8'h3C, 1'b0, 1'b0);
    send(8'h3D, 1'b0, 1'b0);
    checks++;
    if (count !== 5'd2 || rd_data !== 8'h3C || rd_error !== 1'b1) begin
      errors++;
      $display("FAIL err_frame: got count=%0d data=%02h err=%b, want 2/3c/1",
               count, rd_data, rd_error);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (rd_data !== 8'h3D || rd_error !== 1'b0) begin
      errors++;
      $display("FAIL err_next_clean: got data=%02h err=%b, want 3d/0", rd_data, rd_error);
    end
    // Error on the very push cycle belongs to that frame.
    send(8'h77, 1'b1, 1'b0);
    drain("err");
    $display("test_error_accum done");
  endtask

  task automatic test_done_held();
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (count !== 5'd1 || rd_data !== 8'h11) begin
      errors++;
      $display("FAIL done_held: got count=%0d data=%02h, want 1/11", count, rd_data);
    end
    drain("held");
    $display("test_done_held done");
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) send(8'(i), 1'b0, 1'b0);
    send(8'hFF, 1'b0, 1'b0);
    checks++;
    if (full !== 1'b1 || overflow !== 1'b1 || count !== 5'd16) begin
      errors++;
      $display("FAIL overflow_set: got full=%b ovf=%b count=%0d, want 1/1/16",
               full, overflow, count);
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (rd_data !== 8'(i)) begin
        errors++;
        $display("FAIL overflow_pop%0d: got data=%02h, want %02h", i, rd_data, 8'(i));
      end
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    checks++;
    if (overflow !== 1'b1 || empty !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: got ovf=%b empty=%b, want 1/1", overflow, empty);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clr: got ovf=%b, want 0", overflow);
    end
    $display("test_overflow done");
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < DEPTH; i++) send(8'($urandom_range(0, 254)), 1'b0, 1'b0);
    cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (count !== 5'd16 || overflow !== 1'b0 || full !== 1'b1) begin
      errors++;
      $display("FAIL full_push_pop: got count=%0d ovf=%b full=%b, want 16/0/1",
               count, overflow, full);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (mq.size() != 16 || mq[15] !== 9'h055) begin
      errors++;
      $display("FAIL full_push_pop_model: got size=%0d, want 16 ending with 055", mq.size());
    end
    drain("fullpp");
    $display("test_full_push_pop done");
  endtask

  task automatic test_wrap();
    logic [7:0] sent[$];
    int n_rd = 0;
    for (int i = 0; i < 40; i++) begin
      sent.push_back(8'($urandom));
      cycle(1'b1, sent[i], 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== sent[n_rd]) begin
        errors++;
        $display("FAIL wrap_%0d: got valid=%b data=%02h, want 1/%02h", i, rd_valid, rd_data, sent[n_rd]);
      end
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      n_rd++;
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL wrap_empty: got empty=%b, want 1", empty);
    end
    $display("test_wrap done");
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) send(8'h20 + 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'h99, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush: got count=%0d empty=%b ovf=%b valid=%b, want 0/1/0/0",
               count, empty, overflow, rd_valid);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (count !== 5'd0) begin
      errors++;
      $display("FAIL flush_no_late_push: got count=%0d, want 0", count);
    end
    $display("test_flush done");
  endtask

  task automatic test_reset_err();
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    do_reset();
    send(8'h42, 1'b0, 1'b0);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h42 || rd_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: got valid=%b data=%02h err=%b, want 1/42/0",
               rd_valid, rd_data, rd_error);
    end
    drain("rsterr");
    $display("test_reset_err done");
  endtask

  task automatic test_random();
    logic done_lvl = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) done_lvl = ~done_lvl;
      cycle(done_lvl, 8'($urandom), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 19) == 0));
      checks++;
      if (count !== 5'(mq.size()) || rd_valid !== (mq.size() != 0) ||
          full !== (mq.size() == DEPTH) || overflow !== m_ovf ||
          (mq.size() != 0 && {rd_error, rd_data} !== mq[0])) begin
        errors++;
        $display("FAIL random_%0d: got count=%0d valid=%b full=%b ovf=%b head=%03h, want count=%0d ovf=%b head=%03h",
                 i, count, rd_valid, full, overflow, {rd_error, rd_data},
                 mq.size(), m_ovf, (mq.size() != 0) ? mq[0] : 9'h000);
      end
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
      checks++;
      if (almost_full !== (mq.size() >= AF_THRESH)) begin
        errors++;
        $display("FAIL almost_full_%0d: got %b, want %b", i, almost_full, mq.size() >= AF_THRESH);
      end
`endif
    end
    drain("random");
    $display("test_random done");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_push();
    test_error_accum();
    test_done_held();
    test_overflow();
    test_full_push_pop();
    test_wrap();
    test_flush();
    test_reset_err();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_uart_rx_fifo
